// File: rtl/req_arbiter3.sv
// Three-requester arbiter with registered, locked grants and a hold-time limit.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority 2>1>0.
module req_arbiter3 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic [1:0] Q,
  output logic       VALID,
  output logic       EXPIRED
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state_reg;
  logic [2:0]       gnt_reg;
  logic [1:0]       q_reg;
  logic             valid_reg;
  logic             expired_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       mask_reg;
  logic [2:0]       mask_next;
  logic [2:0]       mask_set;
  logic [2:0]       eligible;
  logic [1:0]       pri_hi;
  logic [1:0]       pri_mid;
  logic [1:0]       pri_lo;
  logic [1:0]       win_idx;
  logic             win_any;
  logic             hold_hit;

  assign eligible = REQ & ~mask_reg;
  assign win_any  = |eligible;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_reg;

  // The most recent winner always drops to the lowest slot.
  always_comb begin
    case (last_reg)
      2'd1:    {pri_hi, pri_mid, pri_lo} = {2'd0, 2'd2, 2'd1};
      2'd2:    {pri_hi, pri_mid, pri_lo} = {2'd1, 2'd0, 2'd2};
      default: {pri_hi, pri_mid, pri_lo} = {2'd2, 2'd1, 2'd0};
    endcase
  end
`else
  assign pri_hi  = 2'd2;
  assign pri_mid = 2'd1;
  assign pri_lo  = 2'd0;
`endif

  always_comb begin
    win_idx = pri_lo;
    if (eligible[pri_hi]) begin
      win_idx = pri_hi;
    end else if (eligible[pri_mid]) begin
      win_idx = pri_mid;
    end
  end

  assign hold_hit = (state_reg == GRANT) && REQ[q_reg] && (cnt_reg == HOLD_LIM);
  assign mask_set = hold_hit ? gnt_reg : 3'b000;

  // A masked requester stays blocked until it is seen with its request low.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mask
      assign mask_next[gi] = mask_set[gi] | (mask_reg[gi] & REQ[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gnt_reg     <= 3'b000;
      q_reg       <= 2'b00;
      valid_reg   <= 1'b0;
      expired_reg <= 1'b0;
      cnt_reg     <= '0;
      mask_reg    <= 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
      last_reg    <= 2'd0;
`endif
    end else begin
      expired_reg <= 1'b0;
      mask_reg    <= mask_next;
      case (state_reg)
        IDLE: begin
          if (win_any) begin
            state_reg <= GRANT;
            gnt_reg   <= 3'b001 << win_idx;
            q_reg     <= win_idx;
            valid_reg <= 1'b1;
            cnt_reg   <= CNT_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
            last_reg  <= win_idx;
`endif
          end
        end
        GRANT: begin
          if (!REQ[q_reg] || hold_hit) begin
            state_reg   <= IDLE;
            gnt_reg     <= 3'b000;
            q_reg       <= 2'b00;
            valid_reg   <= 1'b0;
            cnt_reg     <= '0;
            expired_reg <= hold_hit;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign GNT     = gnt_reg;
  assign Q       = q_reg;
  assign VALID   = valid_reg;
  assign EXPIRED = expired_reg;

endmodule

// File: tb/tb_req_arbiter3.sv
// Randomized bench for req_arbiter3 against an owner/mask reference model.
// Follows ARB_ROUND_ROBIN_EN the same way the design does.
module tb_req_arbiter3;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] q;
  logic       valid;
  logic       expired;

  int checks;
  int errors;

  // Reference model state
  int owner;
  int held;
  bit masked [3];
  int last;
  bit exp_pulse;

  req_arbiter3 #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .REQ     (req),
    .GNT     (gnt),
    .Q       (q),
    .VALID   (valid),
    .EXPIRED (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner     = -1;
    held      = 0;
    last      = 0;
    exp_pulse = 0;
    for (int i = 0; i < 3; i++) masked[i] = 0;
  endtask

  task automatic model_step(input logic [2:0] r);
    int order [3];
    bit set_mask [3];
`ifdef ARB_ROUND_ROBIN_EN
    order = '{(last + 2) % 3, (last + 1) % 3, last};
`else
    order = '{2, 1, 0};
`endif
    for (int i = 0; i < 3; i++) set_mask[i] = 0;
    exp_pulse = 0;
    if (owner < 0) begin
      for (int k = 0; k < 3; k++) begin
        if (owner < 0 && r[order[k]] && !masked[order[k]]) begin
          owner = order[k];
          held  = 1;
          last  = order[k];
        end
      end
    end else if (!r[owner]) begin
      owner = -1;
    end else if (held == HOLD) begin
      set_mask[owner] = 1;
      owner     = -1;
      exp_pulse = 1;
    end else begin
      held++;
    end
    for (int i = 0; i < 3; i++) masked[i] = (masked[i] && r[i]) || set_mask[i];
  endtask

  task automatic compare_all(input string tag);
    logic [2:0] exp_gnt;
    logic [1:0] exp_q;
    exp_gnt = (owner >= 0) ? 3'(1 << owner) : 3'b000;
    exp_q   = (owner >= 0) ? 2'(owner) : 2'b00;
    check_val({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check_val({tag, ".q"}, 32'(q), 32'(exp_q));
    check_val({tag, ".valid"}, 32'(valid), 32'(exp_gnt != 3'b000));
    check_val({tag, ".expired"}, 32'(expired), 32'(exp_pulse));
    check_val({tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
    $display("%-8s t=%0t rst_n=%0b req=%03b gnt=%03b q=%0d valid=%0b expired=%0b",
             tag, $time, rst_n, req, gnt, q, valid, expired);
  endtask

  task automatic tick(input string tag, input logic [2:0] r, input logic rs);
    @(negedge clk);
    req   = r;
    rst_n = rs;
    @(posedge clk);
    if (!rs) model_reset();
    else     model_step(r);
    #1 compare_all(tag);
  endtask

  initial begin
    logic [2:0] r;
    checks = 0;
    errors = 0;
    model_reset();

    // Reset with all requests high
    rst_n = 1'b0;
    req   = 3'b111;
    #2 compare_all("rst_hold");
    tick("rst_hold", 3'b111, 1'b0);
    tick("rst_hold", 3'b111, 1'b0);
    tick("rst_rel", 3'b111, 1'b1);
    check_val("rst_first_gnt", 32'(gnt), 32'(3'b100));
    check_val("rst_first_q", 32'(q), 32'(2'b10));

    // Priority, one-cycle gap and release
    tick("idle", 3'b000, 1'b1);
    tick("idle", 3'b000, 1'b1);
    repeat (2) tick("pri", 3'b011, 1'b1);
    repeat (3) tick("drop1", 3'b001, 1'b1);
    // No preemption while 0 holds
    repeat (3) tick("lock", 3'b101, 1'b1);
    tick("rel0", 3'b100, 1'b1);

    // Hold limit: expiry, masked, then re-grant after a drop
    repeat (8) tick("hold", 3'b100, 1'b1);
    tick("unmask", 3'b000, 1'b1);
    repeat (2) tick("regrant", 3'b100, 1'b1);

    // All requests held: expiries rotate through requesters, then unmask
    tick("idle", 3'b000, 1'b1);
    repeat (16) tick("all", 3'b111, 1'b1);
    tick("clrmask", 3'b000, 1'b1);
    repeat (3) tick("all2", 3'b111, 1'b1);

    // Asynchronous reset mid-grant
    tick("idle", 3'b000, 1'b1);
    tick("idle", 3'b000, 1'b1);
    repeat (2) tick("mid", 3'b010, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_val("async_rst_gnt", 32'(gnt), 32'd0);
    check_val("async_rst_valid", 32'(valid), 32'd0);
    check_val("async_rst_q", 32'(q), 32'd0);
    tick("rst_mid", 3'b011, 1'b0);
    tick("rst_rel2", 3'b011, 1'b1);

    // Randomized phase: sticky requests so both releases and expiries occur
    r = 3'b000;
    for (int n = 0; n < 1200; n++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      tick("rand", r, ($urandom_range(0, 299) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
